// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that steers an external 4:1 mux and captures the chosen
// word into a one-entry valid/ready output register with a transfer counter.
module mux4_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_r,
    output logic             S0,
    output logic             S1,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_src;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic       w_any;
    logic       w_can_load;
    logic       w_grant;
    logic       w_found;
    logic [1:0] w_idx;
    logic [1:0] w_sel;
    logic [1:0] w_mux_sel;

    // Scan from the priority pointer upward, wrapping 3 -> 0; first hit wins.
    always_comb begin
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_any      = |req;
    assign w_can_load = !r_out_valid | out_ready;
    assign w_grant    = rst_n & w_any & w_can_load;

    // Selects follow the winner even during a stall so the mux is already set up.
    assign w_mux_sel = !rst_n ? 2'b00 : (w_any ? w_sel : r_ptr);
    assign S0        = w_mux_sel[0];
    assign S1        = w_mux_sel[1];

    always_comb begin
        gnt = 4'b0000;
        if (w_grant) begin
            gnt[w_sel] = 1'b1;
        end
    end

    // A grant loads the register even while it drains, giving one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 2'd0;
            r_xfer_cnt  <= '0;
        end else if (w_grant) begin
            r_ptr       <= w_sel + 2'd1;
            r_out_valid <= 1'b1;
            r_out_data  <= mux_r;
            r_out_src   <= w_sel;
            r_xfer_cnt  <= r_xfer_cnt + CNT_W'(1);
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural arbiter model pushes the
// expected {src,data} on every grant; the head is compared while it is held.
module tb_mux4_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] muxR;
    logic        S0;
    logic        S1;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    logic [3:0]  xfer_cnt;

    logic [31:0] words [4];
    logic [33:0] expQ [$];
    logic [1:0]  mPtr;
    logic [3:0]  mCnt;
    int          total;
    int          bad;

    mux4_rr_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_r     (muxR),
        .S0        (S0),
        .S1        (S1),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    // The external mux: the bench supplies whichever word the selects point at.
    assign muxR = words[{S1, S0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] modelSel(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (r[idx]) return idx;
        end
        return p;
    endfunction

    // Advances the reference model across one rising edge; no checking here.
    task automatic tick();
        logic [1:0] s;
        logic       g;
        s = modelSel(req, mPtr);
        g = rst_n && (|req) && (expQ.size() == 0 || out_ready);
        @(posedge clk);
        if (out_ready && expQ.size() > 0) void'(expQ.pop_front());
        if (g) begin
            expQ.push_back({s, words[s]});
            mPtr = s + 2'd1;
            mCnt = mCnt + 4'd1;
        end
        #1;
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        expQ.delete();
        mPtr = 2'd0;
        mCnt = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        expQ.delete();
        mPtr = 2'd0;
        mCnt = 4'd0;
        #3;
        total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=%b", gnt, 4'b0000); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (xfer_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", xfer_cnt); end
        total++; if ({S1, S0} !== 2'b00) begin bad++; $display("[TB] FAIL reset_sel got=%b want=00", {S1, S0}); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_held got valid=%b gnt=%b want 0/0000", out_valid, gnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL first_gnt got=%b want=0001", gnt); end
        total++; if ({S1, S0} !== 2'b00) begin bad++; $display("[TB] FAIL first_sel got=%b want=00", {S1, S0}); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hA0 || out_src !== 2'd0) begin bad++; $display("[TB] FAIL first_load got v=%b d=%h s=%0d want 1/a0/0", out_valid, out_data, out_src); end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        applyReset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            want = 4'b0001 << (i % 4);
            total++; if (gnt !== want) begin bad++; $display("[TB] FAIL rr_gnt[%0d] got=%b want=%b", i, gnt, want); end
            total++; if ({S1, S0} !== 2'(i % 4)) begin bad++; $display("[TB] FAIL rr_sel[%0d] got=%b want=%0d", i, {S1, S0}, i % 4); end
            if (expQ.size() > 0) begin
                total++; if (out_valid !== 1'b1 || {out_src, out_data} !== expQ[0]) begin bad++; $display("[TB] FAIL rr_out[%0d] got v=%b s=%0d d=%h want s=%0d d=%h", i, out_valid, out_src, out_data, expQ[0][33:32], expQ[0][31:0]); end
            end
            tick();
        end
        total++; if ({out_src, out_data} !== {2'd3, 32'hA3}) begin bad++; $display("[TB] FAIL rr_last got s=%0d d=%h want 3/a3", out_src, out_data); end
        total++; if (xfer_cnt !== 4'd8) begin bad++; $display("[TB] FAIL rr_cnt got=%0d want=8", xfer_cnt); end
    endtask

    task automatic test_backpressure();
        applyReset();
        req       = 4'b0100;
        out_ready = 1'b1;
        #1;
        total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL bp_first_gnt got=%b want=0100", gnt); end
        tick();
        out_ready = 1'b0;
        words[2]  = 32'hB2;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (gnt !== 4'b0000 || {S1, S0} !== 2'b10) begin bad++; $display("[TB] FAIL bp_stall[%0d] got gnt=%b sel=%b want 0000/10", i, gnt, {S1, S0}); end
            total++; if (out_valid !== 1'b1 || {out_src, out_data} !== expQ[0]) begin bad++; $display("[TB] FAIL bp_hold[%0d] got v=%b s=%0d d=%h want s=%0d d=%h", i, out_valid, out_src, out_data, expQ[0][33:32], expQ[0][31:0]); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL bp_release_gnt got=%b want=0100", gnt); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hB2 || out_src !== 2'd2) begin bad++; $display("[TB] FAIL bp_reload got v=%b d=%h s=%0d want 1/b2/2", out_valid, out_data, out_src); end
        total++; if (xfer_cnt !== mCnt) begin bad++; $display("[TB] FAIL bp_cnt got=%0d want=%0d", xfer_cnt, mCnt); end
        req = 4'b0000;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%b want=0", out_valid); end
        words[2] = 32'hA2;
    endtask

    task automatic test_skip_idle();
        applyReset();
        req       = 4'b0001;
        out_ready = 1'b1;
        tick();
        req = 4'b1001;
        #1;
        total++; if (gnt !== 4'b1000 || {S1, S0} !== 2'b11) begin bad++; $display("[TB] FAIL skip_first got gnt=%b sel=%b want 1000/11", gnt, {S1, S0}); end
        tick();
        total++; if ({out_src, out_data} !== expQ[0] || out_src !== 2'd3) begin bad++; $display("[TB] FAIL skip_load3 got s=%0d d=%h want 3/%h", out_src, out_data, words[3]); end
        total++; if (gnt !== 4'b0001 || {S1, S0} !== 2'b00) begin bad++; $display("[TB] FAIL skip_wrap got gnt=%b sel=%b want 0001/00", gnt, {S1, S0}); end
        tick();
        total++; if (out_src !== 2'd0 || out_data !== words[0]) begin bad++; $display("[TB] FAIL skip_load0 got s=%0d d=%h want 0/%h", out_src, out_data, words[0]); end
        req = 4'b0000;
        #1;
        total++; if (gnt !== 4'b0000 || {S1, S0} !== 2'b01) begin bad++; $display("[TB] FAIL idle_sel got gnt=%b sel=%b want 0000/01", gnt, {S1, S0}); end
        tick();
        tick();
        req = 4'b1111;
        #1;
        total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL idle_no_rotate got=%b want=0010", gnt); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_counter_wrap();
        applyReset();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            total++; if ({out_src, out_data} !== expQ[0]) begin bad++; $display("[TB] FAIL wrap_out[%0d] got s=%0d d=%h want s=%0d d=%h", i, out_src, out_data, expQ[0][33:32], expQ[0][31:0]); end
            if (i == 15) begin
                total++; if (xfer_cnt !== 4'd0) begin bad++; $display("[TB] FAIL wrap_zero got=%0d want=0", xfer_cnt); end
            end
        end
        total++; if (xfer_cnt !== 4'd1) begin bad++; $display("[TB] FAIL wrap_cnt got=%0d want=1", xfer_cnt); end
    endtask

    task automatic test_reset_mid();
        applyReset();
        req       = 4'b0010;
        out_ready = 1'b1;
        tick();
        req       = 4'b0000;
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin bad++; $display("[TB] FAIL mid_loaded got v=%b s=%0d want 1/1", out_valid, out_src); end
        rst_n = 1'b0;
        expQ.delete();
        mPtr = 2'd0;
        mCnt = 4'd0;
        #1;
        total++; if (out_valid !== 1'b0 || xfer_cnt !== 4'd0) begin bad++; $display("[TB] FAIL mid_async got v=%b cnt=%0d want 0/0", out_valid, xfer_cnt); end
        #2;
        rst_n     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        #1;
        total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL mid_regrant got=%b want=0001", gnt); end
        tick();
        total++; if (out_src !== 2'd0 || out_data !== 32'hA0 || xfer_cnt !== 4'd1) begin bad++; $display("[TB] FAIL mid_reload got s=%0d d=%h cnt=%0d want 0/a0/1", out_src, out_data, xfer_cnt); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        req       = 4'b0000;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        mPtr      = 2'd0;
        mCnt      = 4'd0;
        for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_skip_idle();
        test_counter_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
